// File: rtl/mu0x_pkg.sv
// mu0x_pkg: shared constants for the MU0X control unit.
//   - opcode values decoded from IR[top 4 bits]
//   - controller state encoding
//   - ALU mode values driven on M
//   - error codes reported on err_code
package mu0x_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_INC  = 2'b10;
    localparam logic [1:0] M_SUB  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

endpackage

// File: rtl/mu0x_wait_timer.sv
// mu0x_wait_timer: counts consecutive stalled cycles of a memory access.
//   clk     in   clock
//   reset   in   synchronous, active-high
//   clear   in   restart the count (any cycle that is not a continuing stall)
//   stall   in   current access is held with mem_ready low
//   expired out  this stall cycle is the MAX_WAIT-th in a row (never when MAX_WAIT=0)
module mu0x_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [W-1:0] LAST = (MAX_WAIT == 0) ? '0 : W'(MAX_WAIT - 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (stall && (wait_cnt != '1)) begin
            // saturate so a disabled timeout never wraps
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (MAX_WAIT != 0) && stall && (wait_cnt == LAST);

endmodule

// File: rtl/mu0x_controller.sv
// mu0x_controller: MU0 fetch/execute sequencer with memory wait states,
// wait timeout, resumable halt, illegal-opcode trap and retire counter.
//   clk, reset          clock; synchronous active-high reset
//   opcode              IR[top 4 bits]
//   acc                 accumulator (sign bit tested by JGE, zero by JNE)
//   mem_ready           memory completes the current Ren/Wen access
//   run                 resume request, honoured only in HALT
//   Asel, Xsel, Ysel    datapath bus selects
//   M                   ALU mode
//   PCen, IRen, ACCen   register load enables
//   Ren, Wen            memory strobes
//   halted, err         state flags
//   err_code            sticky error cause until reset
//   instr_count         saturating retired-instruction count
//
// state | meaning
// INIT  | one cycle clearing PC/IR/ACC
// FETCH | read instruction, PC+1, wait for mem_ready
// EXEC  | execute opcode; memory ops wait for mem_ready
// HALT  | stopped after STP, leave on run
// ERROR | timeout or illegal opcode, leave on reset only
module mu0x_controller
    import mu0x_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic                  mem_ready,
    input  logic                  run,
    output logic                  Asel,
    output logic                  Xsel,
    output logic                  Ysel,
    output logic [1:0]            M,
    output logic                  PCen,
    output logic                  IRen,
    output logic                  ACCen,
    output logic                  Ren,
    output logic                  Wen,
    output logic                  halted,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    state_t     state, state_next;
    logic       stall;
    logic       expired;
    logic       retire;
    logic       err_load;
    logic [1:0] err_val;

    mu0x_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~stall | expired),
        .stall   (stall),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            err_code    <= ERR_NONE;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (err_load) begin
                err_code <= err_val;
            end
            if (retire && (instr_count != '1)) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        Asel       = 1'b0;
        Xsel       = 1'b0;
        Ysel       = 1'b0;
        M          = M_PASS;
        PCen       = 1'b0;
        IRen       = 1'b0;
        ACCen      = 1'b0;
        Ren        = 1'b0;
        Wen        = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        stall      = 1'b0;
        retire     = 1'b0;
        err_load   = 1'b0;
        err_val    = ERR_NONE;
        state_next = state;

        case (state)
            ST_INIT: begin
                PCen       = 1'b1;
                IRen       = 1'b1;
                ACCen      = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                Ren   = 1'b1;
                M     = M_INC;
                IRen  = mem_ready;
                PCen  = mem_ready;
                stall = ~mem_ready;
                if (mem_ready) begin
                    state_next = ST_EXEC;
                end else if (expired) begin
                    state_next = ST_ERROR;
                    err_load   = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDA, OP_STO, OP_ADD, OP_SUB: begin
                        Asel  = 1'b1;
                        stall = ~mem_ready;
                        case (opcode)
                            OP_LDA: begin
                                Ren   = 1'b1;
                                Ysel  = 1'b1;
                                M     = M_PASS;
                                ACCen = mem_ready;
                            end
                            OP_STO: begin
                                Wen  = 1'b1;
                                Xsel = 1'b1;
                            end
                            OP_ADD: begin
                                Ren   = 1'b1;
                                Xsel  = 1'b1;
                                Ysel  = 1'b1;
                                M     = M_ADD;
                                ACCen = mem_ready;
                            end
                            default: begin
                                Ren   = 1'b1;
                                Xsel  = 1'b1;
                                Ysel  = 1'b1;
                                M     = M_SUB;
                                ACCen = mem_ready;
                            end
                        endcase
                        if (mem_ready) begin
                            retire     = 1'b1;
                            state_next = ST_FETCH;
                        end else if (expired) begin
                            state_next = ST_ERROR;
                            err_load   = 1'b1;
                            err_val    = ERR_TIMEOUT;
                        end
                    end
                    OP_JMP: begin
                        PCen       = 1'b1;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OP_JGE: begin
                        PCen       = ~acc[DATA_WIDTH-1];
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OP_JNE: begin
                        PCen       = |acc;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OP_STP: begin
                        retire     = 1'b1;
                        state_next = ST_HALT;
                    end
                    default: begin
                        state_next = ST_ERROR;
                        err_load   = 1'b1;
                        err_val    = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule
